// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states and
// the size/alignment legality check applied when a request is accepted.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW,
    WRITE,
    RESP
  } lsu_state_t;

  // True when the size code is illegal or the offset does not suit the size.
  function automatic logic size_fault(input logic [1:0] size, input logic [1:0] offset);
    logic fault;
    case (size)
      SIZE_BYTE: fault = 1'b0;
      SIZE_HALF: fault = offset[0];
      SIZE_WORD: fault = (offset != 2'b00);
      default:   fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Little-endian byte-lane steering: extracts and extends sub-word load data,
// and merges sub-word store data into an existing memory word.
module byte_lane_unit
  import lsu_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] read_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_result,
  output logic [31:0] merged_word
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Select the addressed lane and sign- or zero-extend it to 32 bits.
  always_comb begin
    case (offset)
      2'd0:    lane_byte = read_word[7:0];
      2'd1:    lane_byte = read_word[15:8];
      2'd2:    lane_byte = read_word[23:16];
      default: lane_byte = read_word[31:24];
    endcase
    lane_half = offset[1] ? read_word[31:16] : read_word[15:0];
    case (size)
      SIZE_BYTE: load_result = is_unsigned ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      SIZE_HALF: load_result = is_unsigned ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default:   load_result = read_word;
    endcase
  end

  // Replace only the addressed lane(s) of the old word with the low store bits.
  always_comb begin
    merged_word = read_word;
    case (size)
      SIZE_BYTE: begin
        case (offset)
          2'd0:    merged_word[7:0]   = store_data[7:0];
          2'd1:    merged_word[15:8]  = store_data[7:0];
          2'd2:    merged_word[23:16] = store_data[7:0];
          default: merged_word[31:24] = store_data[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (offset[1]) merged_word[31:16] = store_data[15:0];
        else           merged_word[15:0]  = store_data[15:0];
      end
      SIZE_WORD: merged_word = store_data;
      default:   merged_word = read_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: accepts one load/store at a time, issues word-aligned
// accesses, performs read-modify-write for sub-word stores and reports
// misaligned, illegal-size or out-of-range requests without touching memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqUnsigned,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqWriteData,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        respError,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData
);

  lsu_state_t  state, next_state;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [31:0] lat_addr;
  logic        lat_error;
  logic [31:0] buffer;
  logic [31:0] resp_data;
  logic        accept;
  logic        req_error;
  logic [31:0] load_result;
  logic [31:0] merged_word;

  assign accept    = reqValid & reqReady;
  assign req_error = size_fault(reqSize, reqAddress[1:0]) |
                     ({2'b00, reqAddress[31:2]} >= 32'(MEM_WORDS));
  assign respData  = resp_data;

  // During RMW the buffer still holds the raw store data, so it feeds the merge.
  byte_lane_unit lanes (
    .offset      (lat_addr[1:0]),
    .size        (lat_size),
    .is_unsigned (lat_unsigned),
    .read_word   (memReadData),
    .store_data  (buffer),
    .load_result (load_result),
    .merged_word (merged_word)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state selection for the request sequence.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_error)              next_state = RESP;
          else if (!reqWrite)         next_state = LOAD;
          else if (reqSize == SIZE_WORD) next_state = WRITE;
          else                        next_state = RMW;
        end
      end
      LOAD:    next_state = RESP;
      RMW:     next_state = WRITE;
      WRITE:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Per-state outputs, all forced low while reset is held so no write can commit.
  always_comb begin
    reqReady     = 1'b0;
    respValid    = 1'b0;
    respError    = 1'b0;
    memRead      = 1'b0;
    memWrite     = 1'b0;
    memAddress   = 32'h0;
    memWriteData = 32'h0;
    if (!reset) begin
      case (state)
        IDLE: reqReady = 1'b1;
        LOAD, RMW: begin
          memRead    = 1'b1;
          memAddress = {lat_addr[31:2], 2'b00};
        end
        WRITE: begin
          memWrite     = 1'b1;
          memAddress   = {lat_addr[31:2], 2'b00};
          memWriteData = buffer;
        end
        RESP: begin
          respValid = 1'b1;
          respError = lat_error;
        end
        default: ;
      endcase
    end
  end

  // Request latch, store buffer and response data; respData only changes at a completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_addr     <= 32'h0;
      lat_error    <= 1'b0;
      buffer       <= 32'h0;
      resp_data    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_size     <= reqSize;
            lat_unsigned <= reqUnsigned;
            lat_addr     <= reqAddress;
            lat_error    <= req_error;
            if (reqWrite) buffer <= reqWriteData;
            if (req_error) resp_data <= 32'h0;
          end
        end
        LOAD:    resp_data <= load_result;
        RMW:     buffer    <= merged_word;
        WRITE:   resp_data <= 32'h0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory port in the single-cycle/pipelined datapath. It accepts one load/store request at a time from the core and issues word-aligned accesses to the data memory. The data memory has a combinational, `memRead`-gated read and writes on the clock edge. The unit does sign/zero extension for sub-word loads and read-modify-write for byte/halfword stores. It reports misaligned or out-of-range accesses instead of touching memory.

## Interface
Parameters:
- `MEM_WORDS`, default 8: number of 32-bit words in the data memory. A word index ≥ `MEM_WORDS` is an error.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `reqValid` in 1: request present.
- `reqReady` out 1: unit idle and able to accept; a transfer happens when `reqValid & reqReady` is high at a rising edge.
- `reqWrite` in 1: 1 = store, 0 = load.
- `reqSize` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `reqUnsigned` in 1: zero-extend sub-word loads; ignored for stores and word loads.
- `reqAddress` in 32: byte address.
- `reqWriteData` in 32: store data, right-justified for sub-word sizes.
- `respValid` out 1: one-cycle completion pulse.
- `respData` out 32: load result, held until the next completion.
- `respError` out 1: qualifies `respValid`; set on misaligned, illegal size or out-of-range access.
- `memRead` out 1: to data memory.
- `memWrite` out 1: to data memory.
- `memAddress` out 32: always `{addr[31:2], 2'b00}` of the latched request, 0 when idle.
- `memWriteData` out 32: to data memory.
- `memReadData` in 32: from data memory, combinational.

## Operation
- Byte lanes are little-endian: offset k = `addr[1:0]` occupies bits [8k+7:8k]; halfword offset 2 occupies [31:16].
- The request is latched on acceptance. Request inputs are don't-care outside the accept cycle.
- Error check at acceptance:
  - halfword with `addr[0]`=1;
  - word with `addr[1:0]`≠0;
  - size 11;
  - `addr>>2` ≥ `MEM_WORDS`.
- States:
  - IDLE: `reqReady`=1. On accept:
    - error → RESP;
    - load → LOAD;
    - word store → WRITE, with buffer = `reqWriteData`;
    - sub-word store → RMW.
  - LOAD: `memRead`=1. At the edge, the extracted and extended lane from `memReadData` goes to `respData`. → RESP.
  - RMW: `memRead`=1. At the edge, the buffer gets `memReadData` with the target lane(s) replaced by the low byte/halfword of the store data. → WRITE.
  - WRITE: `memWrite`=1, `memWriteData`=buffer. Memory commits at the edge. → RESP.
  - RESP: `respValid`=1, and `respError` is set if the request was an error. → IDLE.
- Error responses:
  - `respData` is 0;
  - `memRead` and `memWrite` are never asserted for the request.
- Store responses leave `respData` at 0.
- `memRead`, `memWrite`, `memAddress` and `memWriteData` are 0 in IDLE and RESP.
- `memRead` and `memWrite` are never both high.

## Timing
- Reset values:
  - state IDLE;
  - `reqReady`, `respValid`, `respError`, `memRead` and `memWrite` all 0;
  - `respData`, `memAddress` and `memWriteData` all 0;
  - buffer 0.
- `reqReady` and `memWrite` are gated low combinationally while `reset`=1. A reset arriving in WRITE must not commit the write.
- Latency, counting acceptance edge = cycle 0:
  - `respValid` is high in cycle 2 for loads and word stores;
  - cycle 3 for sub-word stores;
  - cycle 1 for errors.
- The next acceptance is possible in the cycle after RESP. Peak throughput is 1 request per 3 cycles for loads and word stores.
- Reset mid-operation: the request is dropped, no `respValid` is issued, and the unit is IDLE on the cycle after reset deasserts.
- A store followed by a load to the same word sees the new value, because WRITE commits before RESP.

## Structure
- Shared package, `lsu_pkg`:
  - size encodings: `SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`;
  - state enum: IDLE, LOAD, RMW, WRITE, RESP.
- Sub-module `byte_lane_unit`, purely combinational:
  - extract: offset, size, unsigned, word → extended result;
  - merge: offset, size, old word, store data → new word.
- The FSM, request latch and buffer live in the top module.

## Test plan
- Reset, then word store 0xDEADBEEF @0x8, then word load @0x8 → `memWrite` 1 cycle with address 0x8; load gives `respData`=0xDEADBEEF and `respValid` in cycle 2 of each request.
- Byte store 0x80 @0x9 over 0xDEADBEEF → `memRead` then `memWrite` with `memWriteData`=0xDEAD80EF, `respValid` in cycle 3. Then byte load @0x9 → 0xFFFFFF80, and unsigned byte load → 0x00000080.
- Halfword store 0x1234 @0xE, then unsigned halfword load @0xE → 0x00001234. Halfword load @0xD → `respError`=1 in cycle 1, `memRead` and `memWrite` stay 0.
- Word load @0x20 (index 8) and load with size 11 → `respError`=1, `respData`=0.
- Assert `reset` during WRITE of a byte store → `memWrite` low at that edge, memory word unchanged, no `respValid`, `reqReady`=1 the cycle after reset drops.
- Hold `reqValid` high with two queued loads → second accepted only on the IDLE cycle after RESP; `reqReady` is never high in LOAD, RMW, WRITE or RESP.
